fx_add_sched: RTL

Round-robin scheduler that shares one two's-complement fixed-point add-with-round datapath among N requesters. Each requester presents an operand pair under a req/gnt handshake. The block arbitrates, registers the winning operands, performs the aligned add and round-half-away-from-zero, and returns the result tagged with the requester index through an output register with backpressure. It sits between the per-channel filter/accumulator front ends and the shared arithmetic resource.

---
 rtl/fx_add_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fx_add_sched.sv
// Round-robin scheduler sharing one fixed-point add-with-round datapath among N requesters.
// Winning operands are registered in S1; the rounded sum lands in a backpressured output register.
module fx_add_sched #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 3,
    parameter int unsigned AIW = 2,
    parameter int unsigned AFW = 5,
    parameter int unsigned BIW = 4,
    parameter int unsigned BFW = 6,
    parameter int unsigned SIW = 6,
    parameter int unsigned SFW = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             req,
    input  logic [N*(AIW+AFW)-1:0]   a_bus,
    input  logic [N*(BIW+BFW)-1:0]   b_bus,
    output logic [N-1:0]             gnt,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [SIW+SFW-1:0]       out_sum,
    output logic [IDW-1:0]           out_id,
    output logic [15:0]              op_cnt
);

    localparam int unsigned AW   = AIW + AFW;
    localparam int unsigned BW   = BIW + BFW;
    localparam int unsigned OW   = SIW + SFW;
    localparam int unsigned F0   = (AFW > BFW) ? AFW : BFW;
    localparam int unsigned F    = (F0 > SFW + 1) ? F0 : SFW + 1;
    localparam int unsigned SUMW = SIW + F;
    localparam int unsigned GB   = F - SFW - 1;
    localparam int unsigned PW   = $clog2(N);

    logic [PW-1:0]  ptr;
    logic           s1_vld;
    logic [AW-1:0]  s1_a;
    logic [BW-1:0]  s1_b;
    logic [IDW-1:0] s1_id;

    logic           adv_out;
    logic           adv_s1;
    logic           gnt_any;
    logic [PW-1:0]  gnt_idx;
    logic [PW-1:0]  cand;
    int unsigned    arb_sum;
    logic [AW-1:0]  a_sel;
    logic [BW-1:0]  b_sel;

    logic [SUMW-1:0] a_al;
    logic [SUMW-1:0] b_al;
    logic [SUMW-1:0] sum;
    logic [OW-1:0]   trunc;
    logic            guard;
    logic            sticky;
    logic            inc;
    logic [OW-1:0]   rounded;

    assign adv_out = !out_vld || out_rdy;
    assign adv_s1  = !s1_vld || adv_out;

    // Rotating priority search starting at ptr; gnt is held low during reset.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        arb_sum = 0;
        if (rst_n && adv_s1) begin
            for (int unsigned off = 0; off < N; off++) begin
                arb_sum = 32'(ptr) + off;
                if (arb_sum >= N) arb_sum = arb_sum - N;
                cand = PW'(arb_sum);
                if (!gnt_any && req[cand]) begin
                    gnt_any   = 1'b1;
                    gnt_idx   = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
    end

    // Operand select for the winning requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == PW'(i)) begin
                a_sel = a_bus[i*AW +: AW];
                b_sel = b_bus[i*BW +: BW];
            end
        end
    end

    // Align both operands to SIW.F, add, then round half away from zero to SFW bits.
    always_comb begin
        a_al    = {{(SUMW-AW){s1_a[AW-1]}}, s1_a} << (F - AFW);
        b_al    = {{(SUMW-BW){s1_b[BW-1]}}, s1_b} << (F - BFW);
        sum     = a_al + b_al;
        trunc   = sum[SUMW-1 -: OW];
        guard   = sum[GB];
        sticky  = |(sum << (SUMW - GB));
        inc     = guard && (!sum[SUMW-1] || sticky);
        rounded = trunc + OW'(inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_id   <= '0;
            out_vld <= 1'b0;
            out_sum <= '0;
            out_id  <= '0;
            op_cnt  <= '0;
        end else begin
            if (gnt_any) begin
                ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (adv_s1) begin
                s1_vld <= gnt_any;
                if (gnt_any) begin
                    s1_a  <= a_sel;
                    s1_b  <= b_sel;
                    s1_id <= IDW'(gnt_idx);
                end
            end
            if (adv_out) begin
                out_vld <= s1_vld;
                out_sum <= rounded;
                out_id  <= s1_id;
            end
            if (out_vld && out_rdy) begin
                op_cnt <= op_cnt + 16'd1;
            end
        end
    end

endmodule
